thermo_ramp_encoder: RTL and testbench
======================================

THERMO_RAMP_ENCODER -- requirements
Module: thermo_ramp_encoder

Interface
REQ-001 SHALL have parameter N, default 8: width of request value i_a.
REQ-002 SHALL have parameter M, default 8: thermometer width; CW = $clog2(M+1) is the level width.
REQ-003 SHALL have port i_clk, input, 1: single clock, all state on rising edge.
REQ-004 SHALL have port i_rstn, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port i_valid, input, 1: request strobe.
REQ-006 SHALL have port o_ready, output, 1: request accepted when i_valid && o_ready.
REQ-007 SHALL have port i_a, input, N: requested count of set bits.
REQ-008 SHALL have port i_mode, input, 1: 0 = direct, 1 = ramp; sampled on accept.
REQ-009 SHALL have port i_msb_first, input, 1: 0 = fill from bit 0 upward, 1 = fill from bit M-1 downward; sampled on accept.
REQ-010 SHALL have port i_clear, input, 1: synchronous clear.
REQ-011 SHALL have port o_thermo, output, M: registered thermometer code.
REQ-012 SHALL have port o_level, output, CW: registered count of set bits in o_thermo.
REQ-013 SHALL have port o_vf, output, 1: registered overflow flag, i_a > M on last accepted request.
REQ-014 SHALL have port o_done, output, 1: one-cycle pulse, request complete.

Function
REQ-015 SHALL clamp the target to T = min(i_a, M) on accept, with the comparison done at full N/CW width and no wrap.
REQ-016 SHALL encode i_a = 0 as o_thermo = all zeros, o_level = 0.
REQ-017 SHALL drive o_thermo as follows: with LSB fill, bit i = (i < level); with MSB fill, bit M-1-i = (i < level).
REQ-018 SHALL implement FSM states IDLE and RAMP; o_ready = 1 only in IDLE.
REQ-019 SHALL, for a direct-mode accept in cycle t, present o_thermo/o_level = T, o_vf, and o_done = 1 in cycle t+1, and remain in IDLE.
REQ-020 SHALL, for a ramp-mode accept with T == current level, update o_vf and the fill direction and pulse o_done in t+1, and remain in IDLE.
REQ-021 SHALL, for a ramp-mode accept with T != current level L, move level one step toward T per edge starting at the accept edge, so level = L±k in cycle t+k.
REQ-022 SHALL enter RAMP after the accept edge of REQ-021 when |T-L| > 1, and return to IDLE on the edge that produces level = T.
REQ-023 SHALL assert o_done together with the final level, in cycle t+|T-L|, for one cycle only.
REQ-024 SHALL register o_vf on accept and hold it until the next accept or clear.
REQ-025 SHALL apply a fill-direction change on accept and re-map the existing level immediately in the next cycle.
REQ-026 SHALL ignore i_valid while in RAMP, with no queuing.
REQ-027 SHALL give i_clear priority over i_valid and over an in-progress ramp: next cycle level = 0, o_thermo = 0, o_vf = 0, state = IDLE, and no o_done.
REQ-028 SHALL never let o_level exceed M, and o_level SHALL always equal popcount(o_thermo).

Reset
REQ-029 SHALL, while i_rstn = 0, immediately force state = IDLE, o_thermo = 0, o_level = 0, o_vf = 0, o_done = 0, o_ready = 1, LSB fill.
REQ-030 SHALL discard any ramp in progress when reset is asserted, with no o_done after release.
REQ-031 SHALL accept a request in the first cycle after i_rstn deasserts.

Verification
REQ-032 SHALL be verified for direct mode with M=8: i_a=3, LSB -> t+1 o_thermo=8'b00000111, o_level=3, o_done=1, o_vf=0; i_a=0 -> 8'h00; i_a=12 -> 8'hFF, o_vf=1.
REQ-033 SHALL be verified for MSB fill: i_a=3, i_msb_first=1, direct -> 8'b11100000, o_level=3.
REQ-034 SHALL be verified for ramping up then down: from level 0, ramp to 5 -> levels 1,2,3,4,5 in t+1..t+5, o_ready=0 in t+1..t+4, o_done only in t+5; then ramp to 2 -> 4,3,2 with o_done at level 2.
REQ-035 SHALL be verified for a clear mid-ramp: ramp 0->8, i_clear at level 4 -> next cycle level=0, o_thermo=0, IDLE, no o_done; an i_valid in the same cycle is dropped.
REQ-036 SHALL be verified for reset mid-ramp and an equal-target request: i_rstn low at level 3 -> all outputs 0 asynchronously; ramp request equal to current level -> o_done at t+1, level unchanged.

Source files
------------

// File: rtl/thermo_ramp_encoder.sv
// Thermometer-code encoder with direct or one-step-per-cycle ramped level updates.
// Output code, level, overflow and done are all registered; o_ready is high only in IDLE.
module thermo_ramp_encoder #(
  parameter int N = 8,
  parameter int M = 8,
  localparam int CW = $clog2(M + 1)
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic [N-1:0]  i_a,
  input  logic          i_mode,
  input  logic          i_msb_first,
  input  logic          i_clear,
  output logic [M-1:0]  o_thermo,
  output logic [CW-1:0] o_level,
  output logic          o_vf,
  output logic          o_done
);

  localparam int AW = (N > CW) ? N : CW;

  typedef enum logic {IDLE, RAMP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] level_q, level_d;
  logic [CW-1:0] target_q, target_d;
  logic          msb_q, msb_d;
  logic          vf_q, vf_d;
  logic          done_q, done_d;
  logic [M-1:0]  thermo_q, thermo_d;

  logic [AW-1:0] a_ext;
  logic          over;
  logic [CW-1:0] t_clamp;

  function automatic logic [M-1:0] encode(input logic [CW-1:0] lvl, input logic msb);
    logic [M-1:0] t;
    t = '0;
    for (int unsigned i = 0; i < M; i++) begin
      if (msb) t[M-1-i] = (i < 32'(lvl));
      else     t[i]     = (i < 32'(lvl));
    end
    return t;
  endfunction

  // Compare in a width that holds both i_a and M so large requests never wrap.
  always_comb begin
    a_ext   = AW'(i_a);
    over    = a_ext > AW'(M);
    t_clamp = over ? CW'(M) : CW'(i_a);
  end

  always_comb begin
    state_d  = state_q;
    level_d  = level_q;
    target_d = target_q;
    msb_d    = msb_q;
    vf_d     = vf_q;
    done_d   = 1'b0;

    if (i_clear) begin
      state_d = IDLE;
      level_d = '0;
      vf_d    = 1'b0;
    end else if (state_q == IDLE) begin
      if (i_valid) begin
        vf_d  = over;
        msb_d = i_msb_first;
        if (!i_mode || (t_clamp == level_q)) begin
          level_d = t_clamp;
          done_d  = 1'b1;
        end else begin
          // The first ramp step lands on the accept edge itself.
          level_d  = (t_clamp > level_q) ? level_q + CW'(1) : level_q - CW'(1);
          target_d = t_clamp;
          if (level_d == t_clamp) done_d  = 1'b1;
          else                    state_d = RAMP;
        end
      end
    end else begin
      level_d = (target_q > level_q) ? level_q + CW'(1) : level_q - CW'(1);
      if (level_d == target_q) begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
    end

    thermo_d = encode(level_d, msb_d);
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q  <= IDLE;
      level_q  <= '0;
      target_q <= '0;
      msb_q    <= 1'b0;
      vf_q     <= 1'b0;
      done_q   <= 1'b0;
      thermo_q <= '0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      target_q <= target_d;
      msb_q    <= msb_d;
      vf_q     <= vf_d;
      done_q   <= done_d;
      thermo_q <= thermo_d;
    end
  end

  assign o_ready  = (state_q == IDLE);
  assign o_thermo = thermo_q;
  assign o_level  = level_q;
  assign o_vf     = vf_q;
  assign o_done   = done_q;

endmodule

// File: tb/tb_thermo_ramp_encoder.sv
// Directed bench for thermo_ramp_encoder (N=8, M=8): each scenario task drives a
// table of per-cycle vectors and checks the registered outputs one cycle later.
module tb_thermo_ramp_encoder;

  logic       i_clk = 1'b0;
  logic       i_rstn;
  logic       i_valid;
  logic       o_ready;
  logic [7:0] i_a;
  logic       i_mode;
  logic       i_msb_first;
  logic       i_clear;
  logic [7:0] o_thermo;
  logic [3:0] o_level;
  logic       o_vf;
  logic       o_done;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic       v;
    logic [7:0] a;
    logic       mode;
    logic       msb;
    logic       clr;
    logic [7:0] th;
    logic [3:0] lv;
    logic       vf;
    logic       dn;
    logic       rdy;
  } vec_t;

  thermo_ramp_encoder #(.N(8), .M(8)) dut (
    .i_clk       (i_clk),
    .i_rstn      (i_rstn),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_a         (i_a),
    .i_mode      (i_mode),
    .i_msb_first (i_msb_first),
    .i_clear     (i_clear),
    .o_thermo    (o_thermo),
    .o_level     (o_level),
    .o_vf        (o_vf),
    .o_done      (o_done)
  );

  always #5 i_clk = ~i_clk;

  // Drive on the falling edge, then sample 1 time unit after the next rising edge.
  task automatic apply(input vec_t vec);
    @(negedge i_clk);
    i_valid     = vec.v;
    i_a         = vec.a;
    i_mode      = vec.mode;
    i_msb_first = vec.msb;
    i_clear     = vec.clr;
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    vec_t tbl [1];
    i_rstn = 1'b1; i_valid = 1'b0; i_a = '0; i_mode = 1'b0; i_msb_first = 1'b0; i_clear = 1'b0;
    #1 i_rstn = 1'b0;
    #2;
    checks++;
    if ({o_thermo, o_level, o_vf, o_done, o_ready} !== {8'h00, 4'd0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_state: thermo=%h level=%0d vf=%b done=%b ready=%b, expected 00/0/0/0/1",
               o_thermo, o_level, o_vf, o_done, o_ready);
    end
    @(negedge i_clk);
    @(negedge i_clk);
    i_rstn = 1'b1;
    // Accept in the very first cycle after release: direct a=2, LSB.
    tbl = '{'{1'b1, 8'd2, 1'b0, 1'b0, 1'b0, 8'h03, 4'd2, 1'b0, 1'b1, 1'b1}};
    foreach (tbl[i]) begin
      i_valid = tbl[i].v; i_a = tbl[i].a; i_mode = tbl[i].mode; i_msb_first = tbl[i].msb; i_clear = tbl[i].clr;
      @(posedge i_clk);
      #1;
      checks++;
      if ({o_thermo, o_level, o_vf, o_done, o_ready} !== {tbl[i].th, tbl[i].lv, tbl[i].vf, tbl[i].dn, tbl[i].rdy}) begin
        errors++;
        $display("FAIL first_accept: thermo=%h level=%0d vf=%b done=%b ready=%b, expected %h/%0d/%b/%b/%b",
                 o_thermo, o_level, o_vf, o_done, o_ready, tbl[i].th, tbl[i].lv, tbl[i].vf, tbl[i].dn, tbl[i].rdy);
      end
    end
  endtask

  task automatic test_direct();
    vec_t tbl [6];
    tbl = '{
      '{1'b1, 8'd3,  1'b0, 1'b0, 1'b0, 8'h07, 4'd3, 1'b0, 1'b1, 1'b1},
      '{1'b0, 8'd0,  1'b0, 1'b0, 1'b0, 8'h07, 4'd3, 1'b0, 1'b0, 1'b1},
      '{1'b1, 8'd0,  1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1},
      '{1'b1, 8'd12, 1'b0, 1'b0, 1'b0, 8'hFF, 4'd8, 1'b1, 1'b1, 1'b1},
      '{1'b0, 8'd0,  1'b0, 1'b0, 1'b0, 8'hFF, 4'd8, 1'b1, 1'b0, 1'b1},
      '{1'b1, 8'd8,  1'b0, 1'b0, 1'b0, 8'hFF, 4'd8, 1'b0, 1'b1, 1'b1}
    };
    foreach (tbl[i]) begin
      apply(tbl[i]);
      checks++;
      if ({o_thermo, o_level, o_vf, o_done, o_ready} !== {tbl[i].th, tbl[i].lv, tbl[i].vf, tbl[i].dn, tbl[i].rdy}) begin
        errors++;
        $display("FAIL direct[%0d]: thermo=%h level=%0d vf=%b done=%b ready=%b, expected %h/%0d/%b/%b/%b",
                 i, o_thermo, o_level, o_vf, o_done, o_ready, tbl[i].th, tbl[i].lv, tbl[i].vf, tbl[i].dn, tbl[i].rdy);
      end
    end
  endtask

  task automatic test_msb_fill();
    vec_t tbl [2];
    tbl = '{
      '{1'b1, 8'd3, 1'b0, 1'b1, 1'b0, 8'hE0, 4'd3, 1'b0, 1'b1, 1'b1},
      '{1'b1, 8'd7, 1'b0, 1'b1, 1'b0, 8'hFE, 4'd7, 1'b0, 1'b1, 1'b1}
    };
    foreach (tbl[i]) begin
      apply(tbl[i]);
      checks++;
      if ({o_thermo, o_level, o_vf, o_done, o_ready} !== {tbl[i].th, tbl[i].lv, tbl[i].vf, tbl[i].dn, tbl[i].rdy}) begin
        errors++;
        $display("FAIL msb_fill[%0d]: thermo=%h level=%0d vf=%b done=%b ready=%b, expected %h/%0d/%b/%b/%b",
                 i, o_thermo, o_level, o_vf, o_done, o_ready, tbl[i].th, tbl[i].lv, tbl[i].vf, tbl[i].dn, tbl[i].rdy);
      end
    end
  endtask

  task automatic test_ramp_up_down();
    vec_t tbl [9];
    tbl = '{
      '{1'b1, 8'd0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b1},
      '{1'b1, 8'd5, 1'b1, 1'b0, 1'b0, 8'h01, 4'd1, 1'b0, 1'b0, 1'b0},
      '{1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'h03, 4'd2, 1'b0, 1'b0, 1'b0},
      '{1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'h07, 4'd3, 1'b0, 1'b0, 1'b0},
      '{1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'h0F, 4'd4, 1'b0, 1'b0, 1'b0},
      '{1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'h1F, 4'd5, 1'b0, 1'b1, 1'b1},
      '{1'b1, 8'd2, 1'b1, 1'b0, 1'b0, 8'h0F, 4'd4, 1'b0, 1'b0, 1'b0},
      '{1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'h07, 4'd3, 1'b0, 1'b0, 1'b0},
      '{1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'h03, 4'd2, 1'b0, 1'b1, 1'b1}
    };
    foreach (tbl[i]) begin
      apply(tbl[i]);
      checks++;
      if ({o_thermo, o_level, o_vf, o_done, o_ready} !== {tbl[i].th, tbl[i].lv, tbl[i].vf, tbl[i].dn, tbl[i].rdy}) begin
        errors++;
        $display("FAIL ramp_up_down[%0d]: thermo=%h level=%0d vf=%b done=%b ready=%b, expected %h/%0d/%b/%b/%b",
                 i, o_thermo, o_level, o_vf, o_done, o_ready, tbl[i].th, tbl[i].lv, tbl[i].vf, tbl[i].dn, tbl[i].rdy);
      end
    end
  endtask

  task automatic test_clear_mid_ramp();
    vec_t tbl [7];
    tbl = '{
      '{1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1},
      '{1'b1, 8'd9, 1'b1, 1'b0, 1'b0, 8'h01, 4'd1, 1'b1, 1'b0, 1'b0},
      '{1'b1, 8'd0, 1'b0, 1'b0, 1'b0, 8'h03, 4'd2, 1'b1, 1'b0, 1'b0},
      '{1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'h07, 4'd3, 1'b1, 1'b0, 1'b0},
      '{1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'h0F, 4'd4, 1'b1, 1'b0, 1'b0},
      '{1'b1, 8'd1, 1'b0, 1'b0, 1'b1, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1},
      '{1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 1'b0, 1'b0, 1'b1}
    };
    foreach (tbl[i]) begin
      apply(tbl[i]);
      checks++;
      if ({o_thermo, o_level, o_vf, o_done, o_ready} !== {tbl[i].th, tbl[i].lv, tbl[i].vf, tbl[i].dn, tbl[i].rdy}) begin
        errors++;
        $display("FAIL clear_mid_ramp[%0d]: thermo=%h level=%0d vf=%b done=%b ready=%b, expected %h/%0d/%b/%b/%b",
                 i, o_thermo, o_level, o_vf, o_done, o_ready, tbl[i].th, tbl[i].lv, tbl[i].vf, tbl[i].dn, tbl[i].rdy);
      end
    end
  endtask

  task automatic test_reset_mid_ramp();
    vec_t tbl [3];
    tbl = '{
      '{1'b1, 8'd6, 1'b1, 1'b0, 1'b0, 8'h01, 4'd1, 1'b0, 1'b0, 1'b0},
      '{1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'h03, 4'd2, 1'b0, 1'b0, 1'b0},
      '{1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'h07, 4'd3, 1'b0, 1'b0, 1'b0}
    };
    foreach (tbl[i]) begin
      apply(tbl[i]);
      checks++;
      if ({o_thermo, o_level, o_vf, o_done, o_ready} !== {tbl[i].th, tbl[i].lv, tbl[i].vf, tbl[i].dn, tbl[i].rdy}) begin
        errors++;
        $display("FAIL reset_mid_ramp[%0d]: thermo=%h level=%0d vf=%b done=%b ready=%b, expected %h/%0d/%b/%b/%b",
                 i, o_thermo, o_level, o_vf, o_done, o_ready, tbl[i].th, tbl[i].lv, tbl[i].vf, tbl[i].dn, tbl[i].rdy);
      end
    end
    // Drop reset between clock edges: outputs must clear without waiting for a clock.
    #2 i_rstn = 1'b0;
    #1;
    checks++;
    if ({o_thermo, o_level, o_vf, o_done, o_ready} !== {8'h00, 4'd0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL async_reset: thermo=%h level=%0d vf=%b done=%b ready=%b, expected 00/0/0/0/1",
               o_thermo, o_level, o_vf, o_done, o_ready);
    end
    @(negedge i_clk);
    @(negedge i_clk);
    i_rstn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge i_clk);
      #1;
      checks++;
      if ({o_thermo, o_level, o_vf, o_done, o_ready} !== {8'h00, 4'd0, 1'b0, 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL post_reset_idle[%0d]: thermo=%h level=%0d vf=%b done=%b ready=%b, expected 00/0/0/0/1",
                 k, o_thermo, o_level, o_vf, o_done, o_ready);
      end
    end
  endtask

  task automatic test_equal_and_redirect();
    vec_t tbl [9];
    tbl = '{
      '{1'b1, 8'd4,   1'b0, 1'b0, 1'b0, 8'h0F, 4'd4, 1'b0, 1'b1, 1'b1},
      '{1'b1, 8'd4,   1'b1, 1'b0, 1'b0, 8'h0F, 4'd4, 1'b0, 1'b1, 1'b1},
      '{1'b1, 8'd4,   1'b1, 1'b1, 1'b0, 8'hF0, 4'd4, 1'b0, 1'b1, 1'b1},
      '{1'b1, 8'd5,   1'b1, 1'b1, 1'b0, 8'hF8, 4'd5, 1'b0, 1'b1, 1'b1},
      '{1'b1, 8'd200, 1'b1, 1'b0, 1'b0, 8'h3F, 4'd6, 1'b1, 1'b0, 1'b0},
      '{1'b0, 8'd0,   1'b0, 1'b0, 1'b0, 8'h7F, 4'd7, 1'b1, 1'b0, 1'b0},
      '{1'b0, 8'd0,   1'b0, 1'b0, 1'b0, 8'hFF, 4'd8, 1'b1, 1'b1, 1'b1},
      '{1'b1, 8'd9,   1'b1, 1'b0, 1'b0, 8'hFF, 4'd8, 1'b1, 1'b1, 1'b1},
      '{1'b1, 8'd8,   1'b1, 1'b0, 1'b0, 8'hFF, 4'd8, 1'b0, 1'b1, 1'b1}
    };
    foreach (tbl[i]) begin
      apply(tbl[i]);
      checks++;
      if ({o_thermo, o_level, o_vf, o_done, o_ready} !== {tbl[i].th, tbl[i].lv, tbl[i].vf, tbl[i].dn, tbl[i].rdy}) begin
        errors++;
        $display("FAIL equal_redirect[%0d]: thermo=%h level=%0d vf=%b done=%b ready=%b, expected %h/%0d/%b/%b/%b",
                 i, o_thermo, o_level, o_vf, o_done, o_ready, tbl[i].th, tbl[i].lv, tbl[i].vf, tbl[i].dn, tbl[i].rdy);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_direct();
    test_msb_fill();
    test_ramp_up_down();
    test_clear_mid_ramp();
    test_reset_mid_ramp();
    test_equal_and_redirect();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
